// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Ports:
//   bus_valid  master->slave  request valid
//   bus_ready  slave->master  request accepted and completed this cycle
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word-aligned byte address
//   bus_wdata  master->slave  lane-replicated store data
//   bus_wstrb  master->slave  byte write strobes, 0 for reads
//   bus_rdata  slave->master  read data, valid with bus_ready
//   bus_err    slave->master  error flag, qualified by bus_ready
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            bus_valid;
    logic            bus_ready;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic [3:0]      bus_wstrb;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_err;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rdata, bus_err
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rdata, bus_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit between the core datapath and the data bus.
// Accepts one load/store per request, steers store bytes and strobes,
// sign/zero-extends loads, checks alignment, and holds the datapath with
// `stall` while the bus request is outstanding.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   memRead, memWrite    load / store request (both high = fault)
//   funct3               access size and sign (B,H,W,BU,HU)
//   address, writeData   byte address and store data (low-order bits)
//   readData             extended load result, valid in DONE
//   stall                datapath must hold PC
//   fault                one-cycle pulse: misaligned, illegal or bus error
//   bus                  memory bus, master side
// The byte-lane logic assumes a 32-bit bus (4 strobes).
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memRead,
    input  logic                memWrite,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     address,
    input  logic [XLEN-1:0]     writeData,
    output logic [XLEN-1:0]     readData,
    output logic                stall,
    output logic                fault,
    load_store_unit_if.master   bus
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] baddr_q, baddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            fault_q, fault_d;

    logic            op, f3_ok, misal, req_ok, req_bad;
    logic [XLEN-1:0] st_data;
    logic [3:0]      st_strb;
    logic [XLEN-1:0] rd_shift, ld_ext;
    logic            stall_c, fault_c;

    // Request legality and store steering, evaluated on the live inputs.
    always_comb begin
        op      = memRead | memWrite;
        f3_ok   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
        misal   = ((funct3[1:0] == 2'b01) && address[0]) ||
                  ((funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        req_ok  = op && !(memRead && memWrite) && f3_ok && !misal;
        req_bad = op && !req_ok;

        st_data = writeData;
        st_strb = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_data = {4{writeData[7:0]}};
                st_strb = 4'b0001 << address[1:0];
            end
            2'b01: begin
                st_data = {2{writeData[15:0]}};
                st_strb = 4'b0011 << address[1:0];
            end
            default: ;
        endcase
    end

    // Load extraction from the latched byte offset; halfwords are aligned,
    // so the shift is 0 or 16 for them.
    always_comb begin
        rd_shift = bus.bus_rdata >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_ext = {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, rd_shift[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, rd_shift[15:0]};
            default: ld_ext = bus.bus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_lo_d = addr_lo_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        baddr_d   = baddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        stall_c   = 1'b0;
        fault_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    addr_lo_d = address[1:0];
                    funct3_d  = funct3;
                    we_d      = memWrite;
                    baddr_d   = {address[XLEN-1:2], 2'b00};
                    wdata_d   = st_data;
                    wstrb_d   = memWrite ? st_strb : 4'b0000;
                    stall_c   = 1'b1;
                    state_d   = BUS;
                end else if (req_bad) begin
                    fault_c = 1'b1;
                end
            end
            BUS: begin
                stall_c = 1'b1;
                if (bus.bus_ready) begin
                    rdata_d = bus.bus_err ? '0 : ld_ext;
                    fault_d = bus.bus_err;
                    state_d = DONE;
                end
            end
            DONE: begin
                fault_c = fault_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_lo_q <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_lo_q <= addr_lo_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            fault_q   <= fault_d;
        end
    end

    // Combinational outputs are forced low while reset is held, so a
    // request still present on the inputs cannot raise stall/fault.
    assign stall         = rst & stall_c;
    assign fault         = rst & fault_c;
    assign readData      = rdata_q;
    assign bus.bus_valid = (state_q == BUS);
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_wstrb = wstrb_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core datapath and the data-memory bus. It accepts one load or store per request from the datapath, which supplies the ALUResult address, the store data and funct3. It performs byte-lane steering, write strobes, load sign/zero extension and alignment checking, and runs a valid/ready handshake with a variable-latency memory. While a transaction is outstanding it asserts `stall` so the datapath holds PC; it returns `readData` to the register-file write port.

## Interface
Parameters:
- `XLEN`, 32: datapath and bus data width; the address is also XLEN bits.

Ports:
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `memRead`  in  1: current instruction is a load.
- `memWrite`  in  1: current instruction is a store. Both high at once is illegal and is treated as a fault.
- `funct3`  in  3: access size and sign. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU; any other value is a fault.
- `address`  in  XLEN: byte address (ALUResult).
- `writeData`  in  XLEN: store data, with the value in low-order bits.
- `readData`  out  XLEN: extended load result; valid in the DONE cycle.
- `stall`  out  1: datapath must hold PC and architectural state.
- `fault`  out  1: one-cycle pulse for misaligned access, illegal funct3/op or bus error.
- `bus_valid`  out  1: request valid.
- `bus_ready`  in  1: memory accepts the request and completes it in the same cycle.
- `bus_we`  out  1: 1 = write.
- `bus_addr`  out  XLEN: word-aligned address (address with the low 2 bits cleared).
- `bus_wdata`  out  XLEN: lane-replicated store data.
- `bus_wstrb`  out  4: byte write strobes; 0 for reads.
- `bus_rdata`  in  XLEN: read data, sampled when `bus_valid && bus_ready`.
- `bus_err`  in  1: error flag, qualified by `bus_ready`.

## Operation
- States: IDLE, BUS, DONE.
- **IDLE**:
  - If `memRead|memWrite` and the access is legal and aligned: latch address[1:0], funct3, we, wdata and wstrb; go to BUS.
  - If the access is illegal or misaligned: pulse `fault` combinationally in this cycle, issue no bus request, hold `stall` low, stay in IDLE.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0.
- **BUS**:
  - `bus_valid` is high.
  - `bus_addr`, `bus_we`, `bus_wdata` and `bus_wstrb` come from registers and are stable until `bus_ready`.
  - On `bus_ready`: capture the extended `bus_rdata`, or 0 if `bus_err`, into the `readData` register; register the fault flag (= `bus_err`); go to DONE.
- **DONE**:
  - `stall` is low, so the instruction retires at this edge.
  - Request inputs are ignored.
  - `fault` is driven from the registered flag.
  - Go to IDLE.
- Store steering:
  - B: wdata = {4{wd[7:0]}}, wstrb = 0001 << addr[1:0].
  - H: wdata = {2{wd[15:0]}}, wstrb = 0011 << addr[1:0].
  - W: wdata = wd, wstrb = 1111.
- Load extraction: select the byte or halfword using latched addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- `readData` holds its value until the next capture.

## Timing
- `stall` = (IDLE && (memRead|memWrite) && legal && aligned) || BUS. It is combinational from the inputs in IDLE.
- Minimum load/store latency is 3 cycles:
  - cycle 0: IDLE, request seen, `stall` = 1;
  - cycle 1: BUS, `bus_ready` = 1;
  - cycle 2: DONE, `readData` valid, `stall` = 0.
- Each additional cycle of `bus_ready` low adds one stall cycle. There is no timeout.
- At most one outstanding bus request; `bus_valid` is never high in IDLE or DONE.
- Reset values: state IDLE, `bus_valid` 0, `bus_we` 0, `bus_wstrb` 0, `bus_addr` 0, `bus_wdata` 0, `readData` 0, `fault` 0, `stall` 0.
- Reset asserted mid-transaction (BUS or DONE): `bus_valid` drops asynchronously and the state returns to IDLE. The memory must discard the request.
- Non-memory instructions in IDLE: no outputs change and `stall` = 0.

## Test plan
- Reset is released, then LW at 0x100 with 0 wait states and bus_rdata=0xDEADBEEF → `bus_valid` high for 1 cycle, `bus_addr` 0x100, `stall` high for 2 cycles, `readData` 0xDEADBEEF in DONE, `fault` 0.
- LB at 0x103 with bus_rdata=0x80112233 → `readData` 0xFFFFFF80; LBU at the same address → 0x00000080; LHU at 0x102 → 0x00008011.
- SB at 0x201 with writeData 0x000000A5 and 3 wait states → `bus_wdata` 0xA5A5A5A5, `bus_wstrb` 0010, `bus_we` 1, `bus_addr` 0x200, and these held stable over all 4 BUS cycles; `stall` high for 5 cycles.
- LW at 0x102 → `fault` pulses in the same cycle, `bus_valid` never asserts, `stall` 0. funct3=011 or memRead&memWrite gives the same response.
- LW with bus_err=1 and bus_ready=1 → DONE cycle with `fault`=1 and `readData` 0.
- `rst` pulsed low while in BUS with `bus_ready` low → `bus_valid` drops immediately; after release, the next LW completes normally.
